// File: rtl/apb_if.sv
// APB3 pin bundle shared by the master, the memory slave and any monitor.
// The pslverr wire exists only when APB_SLV_PSLVERR_EN is defined.
interface apb_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
`ifdef APB_SLV_PSLVERR_EN
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );
  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
`else
  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );
  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );
`endif
endinterface

// File: rtl/apb_mem_slave.sv
// APB3 completer backed by DEPTH 32-bit registers with WAIT_CYCLES wait states.
// Optional error response on invalid addresses: define APB_SLV_PSLVERR_EN.
module apb_mem_slave #(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic  pclk,
  input  logic  prst,
  apb_if.slave  bus
);
  localparam int         AW      = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, READY = 2'd2} state_t;

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [31:0] addr_r, addr_s;
  logic        write_r, write_s;
  logic [31:0] wdata_r, wdata_s;
  logic        pready_r, pready_s;
  logic [31:0] prdata_r, prdata_s;
  logic        we_s;
  logic        enter_ready_s;
  logic [31:0] ld_addr_s;
  logic        ld_write_s;
  logic [31:0] mem_r [DEPTH];
`ifdef APB_SLV_PSLVERR_EN
  logic        pslverr_r, pslverr_s;
`endif

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> (AW + 2)) == 32'd0);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return a[AW+1:2];
  endfunction

  // Next-state and next-output logic for the transfer FSM
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    addr_s        = addr_r;
    write_s       = write_r;
    wdata_s       = wdata_r;
    pready_s      = pready_r;
    prdata_s      = prdata_r;
    we_s          = 1'b0;
    enter_ready_s = 1'b0;
    ld_addr_s     = addr_r;
    ld_write_s    = write_r;
`ifdef APB_SLV_PSLVERR_EN
    pslverr_s     = pslverr_r;
`endif
    case (state_r)
      IDLE: begin
        if (bus.psel && !bus.penable) begin
          addr_s     = bus.paddr;
          write_s    = bus.pwrite;
          wdata_s    = bus.pwdata;
          cnt_s      = WAIT_LD;
          ld_addr_s  = bus.paddr;
          ld_write_s = bus.pwrite;
          if (WAIT_CYCLES == 0) begin
            state_s       = READY;
            enter_ready_s = 1'b1;
          end else begin
            state_s = WAIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (!bus.psel) begin
          state_s  = IDLE;
          pready_s = 1'b0;
        end else if (bus.penable) begin
          if (cnt_r == 4'd1) begin
            state_s       = READY;
            enter_ready_s = 1'b1;
          end else begin
            cnt_s = cnt_r - 4'd1;
          end
        end else begin
          state_s = WAIT;
        end
      end
      READY: begin
        // pready is always high here, so psel & penable completes the transfer
        if (!bus.psel) begin
          state_s  = IDLE;
          pready_s = 1'b0;
`ifdef APB_SLV_PSLVERR_EN
          pslverr_s = 1'b0;
`endif
        end else if (bus.penable) begin
          we_s     = write_r && addr_ok(addr_r);
          state_s  = IDLE;
          pready_s = 1'b0;
`ifdef APB_SLV_PSLVERR_EN
          pslverr_s = 1'b0;
`endif
        end else begin
          state_s = READY;
        end
      end
      default: begin
        state_s  = IDLE;
        pready_s = 1'b0;
      end
    endcase

    if (enter_ready_s) begin
      pready_s = 1'b1;
`ifdef APB_SLV_PSLVERR_EN
      pslverr_s = !addr_ok(ld_addr_s);
`endif
      if (!ld_write_s) begin
        prdata_s = addr_ok(ld_addr_s) ? mem_r[word_idx(ld_addr_s)] : 32'd0;
      end else begin
        prdata_s = prdata_r;
      end
    end else begin
      prdata_s = prdata_s;
    end
  end

  // FSM, captured request and registered bus outputs
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      addr_r   <= 32'd0;
      write_r  <= 1'b0;
      wdata_r  <= 32'd0;
      pready_r <= 1'b0;
      prdata_r <= 32'd0;
`ifdef APB_SLV_PSLVERR_EN
      pslverr_r <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      addr_r   <= addr_s;
      write_r  <= write_s;
      wdata_r  <= wdata_s;
      pready_r <= pready_s;
      prdata_r <= prdata_s;
`ifdef APB_SLV_PSLVERR_EN
      pslverr_r <= pslverr_s;
`endif
    end
  end

  // Register bank, committed only on a completed valid write
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'd0;
      end
    end else if (we_s) begin
      mem_r[word_idx(addr_r)] <= wdata_r;
    end else begin
      mem_r <= mem_r;
    end
  end

  assign bus.prdata  = prdata_r;
  assign bus.pready  = pready_r;
`ifdef APB_SLV_PSLVERR_EN
  assign bus.pslverr = pslverr_r;
`endif
endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: unit 0 has no wait states, unit 1 has three.
// A transaction-level model predicts per-cycle outputs; a negedge process compares.
module tb_apb_mem_slave;
  logic        pclk = 1'b0;
  logic        prst = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = 32'd0;
  logic [31:0] pwdata = 32'd0;
  int          sel = 0;
  bit          chk_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic        exp_rdy [2];
  logic        exp_err [2];
  logic [31:0] exp_rd  [2];
  logic [31:0] mdl     [2][16];

  apb_if b0 ();
  apb_if b1 ();

  assign b0.psel    = psel && (sel == 0);
  assign b0.penable = penable;
  assign b0.pwrite  = pwrite;
  assign b0.paddr   = paddr;
  assign b0.pwdata  = pwdata;
  assign b1.psel    = psel && (sel == 1);
  assign b1.penable = penable;
  assign b1.pwrite  = pwrite;
  assign b1.paddr   = paddr;
  assign b1.pwdata  = pwdata;

  apb_mem_slave #(.DEPTH(16), .WAIT_CYCLES(0)) dut0 (.pclk(pclk), .prst(prst), .bus(b0));
  apb_mem_slave #(.DEPTH(16), .WAIT_CYCLES(3)) dut1 (.pclk(pclk), .prst(prst), .bus(b1));

  always #5 pclk = ~pclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both units against the model
  always @(negedge pclk) begin
    if (chk_en) begin
      chk("u0.pready", {31'd0, b0.pready}, {31'd0, exp_rdy[0]});
      chk("u0.prdata", b0.prdata, exp_rd[0]);
      chk("u1.pready", {31'd0, b1.pready}, {31'd0, exp_rdy[1]});
      chk("u1.prdata", b1.prdata, exp_rd[1]);
`ifdef APB_SLV_PSLVERR_EN
      chk("u0.pslverr", {31'd0, b0.pslverr}, {31'd0, exp_err[0]});
      chk("u1.pslverr", {31'd0, b1.pslverr}, {31'd0, exp_err[1]});
`endif
    end
  end

  task automatic model_clear();
    for (int u = 0; u < 2; u++) begin
      exp_rdy[u] = 1'b0;
      exp_err[u] = 1'b0;
      exp_rd[u]  = 32'd0;
      for (int w = 0; w < 16; w++) mdl[u][w] = 32'd0;
    end
  endtask

  // One APB transfer on unit u; abort_k >= 0 drops psel after abort_k access cycles
  task automatic xfer(input int u, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input int abort_k);
    int  w;
    int  nacc;
    bit  valid;
    w     = (u == 0) ? 0 : 3;
    valid = (a % 4 == 0) && (a < 32'd64);
    sel = u; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    nacc = (abort_k >= 0) ? abort_k : w + 1;
    for (int j = 1; j <= nacc; j++) begin
      penable = 1'b1;
      if (j == w + 1) begin
        exp_rdy[u] = 1'b1;
        exp_err[u] = !valid;
        if (!wr) exp_rd[u] = valid ? mdl[u][a / 4] : 32'd0;
      end
      @(posedge pclk); #1;
    end
    exp_rdy[u] = 1'b0;
    exp_err[u] = 1'b0;
    if (abort_k < 0 && wr && valid) mdl[u][a / 4] = d;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic idle(input int n);
    psel = 1'b0; penable = 1'b0;
    repeat (n) begin
      @(posedge pclk); #1;
    end
  endtask

  initial begin
    model_clear();
    #2 prst = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    chk("rst.u0.pready", {31'd0, b0.pready}, 32'd0);
    chk("rst.u1.pready", {31'd0, b1.pready}, 32'd0);
    chk("rst.u0.prdata", b0.prdata, 32'd0);
    chk("rst.u1.prdata", b1.prdata, 32'd0);
    prst = 1'b0;
    chk_en = 1'b1;
    idle(1);

    for (int i = 0; i < 16; i++) xfer(0, 1'b0, 32'(i * 4), 32'd0, -1);

    // back-to-back write then read, no idle cycle between
    xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, -1);
    xfer(0, 1'b0, 32'h08, 32'd0, -1);
    chk("u0.rd08", b0.prdata, 32'hDEADBEEF);
    chk("mdl.u0.w2", mdl[0][2], 32'hDEADBEEF);
    xfer(0, 1'b0, 32'h0C, 32'd0, -1);
    chk("u0.rd0C", b0.prdata, 32'd0);
    idle(2);

    xfer(1, 1'b1, 32'h04, 32'h12345678, -1);
    xfer(1, 1'b0, 32'h04, 32'd0, -1);
    chk("u1.rd04", b1.prdata, 32'h12345678);
    idle(1);

    // invalid addresses on both units, prdata made nonzero first
    for (int u = 0; u < 2; u++) begin
      xfer(u, 1'b1, 32'h40, 32'hA5A5A5A5, -1);
      xfer(u, 1'b1, 32'h02, 32'h5A5A5A5A, -1);
      xfer(u, 1'b0, (u == 0) ? 32'h08 : 32'h04, 32'd0, -1);
      xfer(u, 1'b0, 32'h40, 32'd0, -1);
      chk("inv.rd40", (u == 0) ? b0.prdata : b1.prdata, 32'd0);
      xfer(u, 1'b0, 32'h02, 32'd0, -1);
      xfer(u, 1'b0, 32'h00, 32'd0, -1);
      chk("inv.rd00", (u == 0) ? b0.prdata : b1.prdata, 32'd0);
      idle(1);
    end

    // abort a write in its second WAIT cycle
    xfer(1, 1'b1, 32'h10, 32'h11111111, -1);
    xfer(1, 1'b1, 32'h10, 32'h22222222, 1);
    idle(2);
    chk("abort.pready", {31'd0, b1.pready}, 32'd0);
    xfer(1, 1'b0, 32'h10, 32'd0, -1);
    chk("abort.rd10", b1.prdata, 32'h11111111);
    idle(1);

    // reset during WAIT of a write
    xfer(1, 1'b0, 32'h04, 32'd0, -1);
    sel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hCAFEF00D;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #2;
    prst = 1'b1; psel = 1'b0; penable = 1'b0;
    model_clear();
    #1;
    chk("midrst.u1.pready", {31'd0, b1.pready}, 32'd0);
    chk("midrst.u1.prdata", b1.prdata, 32'd0);
    chk("midrst.u0.prdata", b0.prdata, 32'd0);
    @(posedge pclk); #1;
    prst = 1'b0;
    idle(1);
    xfer(1, 1'b0, 32'h04, 32'd0, -1);
    xfer(1, 1'b0, 32'h0C, 32'd0, -1);
    chk("postrst.u1.rd0C", b1.prdata, 32'd0);
    xfer(0, 1'b0, 32'h08, 32'd0, -1);
    chk("postrst.u0.rd08", b0.prdata, 32'd0);

    // back-to-back on the wait-state unit
    xfer(1, 1'b1, 32'h3C, 32'h0BADC0DE, -1);
    xfer(1, 1'b0, 32'h3C, 32'd0, -1);
    chk("u1.rd3C", b1.prdata, 32'h0BADC0DE);
    idle(2);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

APB3-style completer that sits directly downstream of the APB master and responds on the shared APB bus signals. It holds a bank of 32-bit registers, services single read/write transfers, and inserts a programmable number of wait states through `pready`. Bus functional models and the monitor observe it through the same pin-level signals.

## Interface
- `DEPTH`, 16 — number of 32-bit words; power of two, range 2..256.
- `WAIT_CYCLES`, 0 — wait states inserted per transfer; range 0..15.
- `pclk` input 1 — bus clock; all state changes on its rising edge.
- `prst` input 1 — reset; asynchronous, active-high.
- `psel` input 1 — slave select.
- `penable` input 1 — access-phase qualifier.
- `pwrite` input 1 — 1 = write, 0 = read.
- `paddr` input 32 — byte address.
- `pwdata` input 32 — write data.
- `prdata` output 32 — read data; registered.
- `pready` output 1 — transfer-complete strobe; registered.
- `pslverr` output 1 — error response; present only with `APB_SLV_PSLVERR_EN`.

## Operation
- `AW = log2(DEPTH)`. The word index is `paddr[AW+1:2]`.
- An address is valid when `paddr[1:0]==0` and `paddr[31:AW+2]==0`.
- Storage: `DEPTH` registers. All registers are cleared to 0 on reset.
- FSM states: IDLE, WAIT, READY.
  - IDLE: a sampled setup (`psel=1`, `penable=0`) captures `paddr`, `pwrite` and `pwdata`, and loads `cnt=WAIT_CYCLES`.
    - If `WAIT_CYCLES==0`, go to READY.
    - Otherwise go to WAIT.
  - WAIT: on each edge with `psel & penable`:
    - If `cnt==1`, go to READY.
    - Otherwise decrement `cnt`.
  - Entering READY drives `pready<=1`. For a valid read it also drives `prdata<=mem[index]`.
  - READY: the edge with `psel & penable & pready` completes the transfer.
    - A valid write commits `mem[index]<=pwdata`.
    - `pready<=0`, and the FSM returns to IDLE.
- Read of an invalid address: `prdata<=0`. Write to an invalid address: discarded.
- `prdata` holds its last value outside read completions. Writes never change it.
- `psel` deasserted in WAIT or READY (protocol abort): go to IDLE, `pready<=0`, no write commits.
- Back-to-back transfers:
  - The cycle after completion is the next setup. It is sampled in IDLE with no idle cycle required.
  - A setup seen in the same edge as completion is ignored. By APB rule it cannot occur.
- Registers only. No combinational path from inputs to outputs.

## Timing
- Reset values: `prdata=0`, `pready=0`, `pslverr=0`, state IDLE, `cnt=0`, memory all 0.
- Deasserting `prst` takes effect on the next `pclk` edge.
- Access phase length is `WAIT_CYCLES+1` cycles. `pready` is high only in the last of them.
- `pready` is high for exactly one cycle per transfer.
- Write latency: data is visible to a read whose setup begins the cycle after write completion.
- Reset asserted mid-transfer: outputs and memory clear immediately. The in-flight write is lost.

## Configuration
- `APB_SLV_PSLVERR_EN` defined:
  - The `pslverr` port exists.
  - It is driven 1 together with `pready` for an invalid address, and 0 otherwise.
  - Invalid reads return `prdata=0`. Invalid writes are discarded.
- Not defined: the port is absent and invalid accesses complete silently with the same data behaviour.

## Test plan
- Reset then read all words, `WAIT_CYCLES=0` -> each `prdata=0`, `pready` in the first access cycle, 2 cycles per transfer.
- Write `0xDEADBEEF` to `0x08`, then read `0x08` -> `0xDEADBEEF`. A read of `0x0C` returns 0.
- `WAIT_CYCLES=3`, write then read `0x04` -> `pready` low for 3 access cycles and high on the 4th. Data matches.
- With `DEPTH=16`, write `0x40` then read `0x40` and read `0x02` -> `prdata=0`; `pslverr=1` with the macro, port absent without it. Memory is unchanged.
- Drop `psel` in the 2nd WAIT cycle of a write to `0x10`, then read `0x10` -> old value. FSM back in IDLE and `pready=0`.
- Assert `prst` during the WAIT state of a write -> `pready=0` and `prdata=0` at once. A subsequent read returns 0.
